lcd_i2c_byte_writer: RTL and testbench

LCD_I2C_BYTE_WRITER -- requirements
Module: lcd_i2c_byte_writer

---
 rtl/lcd_i2c_byte_writer.sv | 196 +++++++++++++++++++
 tb/tb_lcd_i2c_byte_writer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_i2c_byte_writer.sv
// lcd_i2c_byte_writer: sends one LCD byte to a PCF8574 backpack over I2C.
// The byte goes out in 4-bit mode as four expander frames (high nibble with EN
// pulsed, then low nibble with EN pulsed), framed by START/STOP.
// SCL is push-pull from the single master; SDA is open-drain.
module lcd_i2c_byte_writer #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h27,
  parameter int unsigned QTR        = 5,
  parameter bit          BACKLIGHT  = 1'b1
) (
  input  logic       clk_1MHz,
  input  logic       rst_n,
  input  logic       ena_write,
  input  logic [7:0] data,
  input  logic       cmd_data,
  output logic       done_write,
  output logic       busy,
  output logic       ack_err,
  output logic       scl,
  inout  wire        sda
);

  localparam int unsigned QW    = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [QW-1:0] QLAST = QW'(QTR - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_ACK,
    S_STOP,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    quarter_q, quarter_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    byte_q, byte_d;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d;
  logic          nack_q, nack_d;
  logic          sda_low_q;
  logic          scl_d, sda_low_d;
  logic [7:0]    tx_byte;
  logic          qend;
  logic          sda_in;

  assign sda    = sda_low_q ? 1'b0 : 1'bz;
  assign sda_in = sda;
  assign qend   = (qcnt_q == QLAST);

  // Position sequencer: quarter counter, quarter index, bit and byte counters.
  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    quarter_d = quarter_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    data_d    = data_q;
    rs_d      = rs_q;
    nack_d    = nack_q;
    case (state_q)
      S_IDLE: begin
        if (ena_write) begin
          state_d   = S_START;
          data_d    = data;
          rs_d      = cmd_data;
          nack_d    = 1'b0;
          qcnt_d    = '0;
          quarter_d = '0;
          bit_d     = '0;
          byte_d    = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        // ACK is sampled on the last cycle of Q2, while SCL is high.
        if (state_q == S_ACK && quarter_q == 2'd2 && qend && sda_in) begin
          nack_d = 1'b1;
        end
        if (!qend) begin
          qcnt_d = qcnt_q + QW'(1);
        end else begin
          qcnt_d    = '0;
          quarter_d = quarter_q + 2'd1;
          if (quarter_q == 2'd3) begin
            case (state_q)
              S_START: begin
                state_d = S_BIT;
                bit_d   = '0;
                byte_d  = '0;
              end
              S_BIT: begin
                if (bit_q == 3'd7) begin
                  state_d = S_ACK;
                end else begin
                  bit_d = bit_q + 3'd1;
                end
              end
              S_ACK: begin
                // A NACK finishes its slot, then skips any remaining bytes.
                if (nack_q || byte_q == 3'd4) begin
                  state_d = S_STOP;
                  bit_d   = '0;
                  byte_d  = '0;
                end else begin
                  state_d = S_BIT;
                  bit_d   = '0;
                  byte_d  = byte_q + 3'd1;
                end
              end
              S_STOP: begin
                state_d = S_DONE;
              end
              default: begin
                state_d = S_IDLE;
              end
            endcase
          end
        end
      end
    endcase
  end

  // Byte on the wire for the upcoming slot: address, then the four frames.
  always_comb begin
    tx_byte = '0;
    case (byte_d)
      3'd0:    tx_byte = {SLAVE_ADDR, 1'b0};
      3'd1:    tx_byte = {data_q[7:4], BACKLIGHT, 1'b1, 1'b0, rs_q};
      3'd2:    tx_byte = {data_q[7:4], BACKLIGHT, 1'b0, 1'b0, rs_q};
      3'd3:    tx_byte = {data_q[3:0], BACKLIGHT, 1'b1, 1'b0, rs_q};
      3'd4:    tx_byte = {data_q[3:0], BACKLIGHT, 1'b0, 1'b0, rs_q};
      default: tx_byte = '0;
    endcase
  end

  // Bus levels for the upcoming cycle, derived from the next position so
  // that the registered pins line up with the quarter they belong to.
  always_comb begin
    scl_d     = 1'b1;
    sda_low_d = 1'b0;
    case (state_d)
      S_START: sda_low_d = quarter_d[1];
      S_BIT: begin
        scl_d     = quarter_d[1];
        sda_low_d = ~tx_byte[3'd7 - bit_d];
      end
      S_ACK:   scl_d = quarter_d[1];
      S_STOP: begin
        scl_d     = (quarter_d != 2'd0);
        sda_low_d = ~quarter_d[1];
      end
      default: begin
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
      end
    endcase
  end

  // Transaction FSM state and registered outputs.
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      qcnt_q     <= '0;
      quarter_q  <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      data_q     <= '0;
      rs_q       <= 1'b0;
      nack_q     <= 1'b0;
      scl        <= 1'b1;
      sda_low_q  <= 1'b0;
      done_write <= 1'b0;
      busy       <= 1'b0;
      ack_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      qcnt_q     <= qcnt_d;
      quarter_q  <= quarter_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      data_q     <= data_d;
      rs_q       <= rs_d;
      nack_q     <= nack_d;
      scl        <= scl_d;
      sda_low_q  <= sda_low_d;
      done_write <= (state_d == S_DONE);
      busy       <= (state_d != S_IDLE);
      ack_err    <= (state_d == S_DONE) && nack_d;
    end
  end

endmodule

// File: tb/tb_lcd_i2c_byte_writer.sv
// Directed bench for lcd_i2c_byte_writer with an I2C slave model on the bus.
`timescale 1ns/1ps
module tb_lcd_i2c_byte_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena_write;
  logic [7:0] data;
  logic       cmd_data;
  logic       done_write, busy, ack_err, scl;
  wire        sda;
  logic       slave_low = 1'b0;

  assign sda = slave_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #500 clk = ~clk;

  lcd_i2c_byte_writer #(
    .SLAVE_ADDR(7'h27),
    .QTR(5),
    .BACKLIGHT(1'b1)
  ) dut (
    .clk_1MHz(clk),
    .rst_n(rst_n),
    .ena_write(ena_write),
    .data(data),
    .cmd_data(cmd_data),
    .done_write(done_write),
    .busy(busy),
    .ack_err(ack_err),
    .scl(scl),
    .sda(sda)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Bus monitor / slave model, sampled on the falling clock edge.
  logic       mon_clr   = 1'b0;
  logic       nack_addr = 1'b0;
  logic       prev_scl  = 1'b1;
  logic       prev_sda  = 1'b1;
  logic [7:0] shreg     = '0;
  logic [7:0] bytes_q[$];
  int bitn = 0, n_start = 0, n_stop = 0, n_bitclk = 0, n_ack_hi = 0, n_done = 0;

  always @(negedge clk) begin
    logic s_scl, s_sda;
    s_scl = scl;
    s_sda = sda;
    if (mon_clr) begin
      bytes_q.delete();
      bitn = 0; n_start = 0; n_stop = 0; n_bitclk = 0; n_ack_hi = 0; n_done = 0;
      slave_low = 1'b0;
    end else begin
      if (done_write) n_done++;
      if (prev_scl && s_scl && (prev_sda !== s_sda)) begin
        if (s_sda == 1'b0) n_start++;
        else begin
          n_stop++;
          n_bitclk--;  // the SCL rise inside STOP is not a bit clock
        end
        bitn = 0;
      end else if (!prev_scl && s_scl) begin
        n_bitclk++;
        if (bitn < 8) begin
          shreg = {shreg[6:0], s_sda};
          bitn++;
          if (bitn == 8) bytes_q.push_back(shreg);
        end else begin
          if (s_sda) n_ack_hi++;
          bitn = 9;
        end
      end else if (prev_scl && !s_scl) begin
        if (bitn == 8) slave_low = !(nack_addr && bytes_q.size() == 1);
        else if (bitn == 9) begin
          slave_low = 1'b0;
          bitn = 0;
        end
      end
    end
    prev_scl = s_scl;
    prev_sda = s_sda;
  end

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic c);
    @(negedge clk);
    data = d; cmd_data = c; ena_write = 1'b1;
    @(posedge clk);
    #1 ena_write = 1'b0;
  endtask

  // Waits for done_write (cycle 1 = first cycle after acceptance), then checks
  // timing, flags, decoded bytes and bus framing of the transaction.
  task automatic finish_txn(input string tag, input int start, input int exp_cyc,
                            input logic exp_err, input int nb, input logic [39:0] exp_b,
                            input int exp_clk);
    int cyc;
    logic [31:0] got;
    cyc = 0;
    for (int i = start + 1; i <= 3000; i++) begin
      @(negedge clk);
      if (done_write) begin
        cyc = i;
        break;
      end
    end
    check({tag, "_done_cycle"}, cyc, exp_cyc);
    check({tag, "_ack_err"}, ack_err, exp_err);
    check({tag, "_busy_at_done"}, busy, 1'b1);
    @(negedge clk);
    check({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_done_after"}, done_write, 1'b0);
    check({tag, "_nbytes"}, bytes_q.size(), nb);
    for (int i = 0; i < nb; i++) begin
      got = (i < bytes_q.size()) ? 32'(bytes_q[i]) : 32'hDEAD;
      check($sformatf("%s_byte%0d", tag, i), got, exp_b[8*(nb-1-i) +: 8]);
    end
    check({tag, "_starts"}, n_start, 1);
    check({tag, "_stops"}, n_stop, 1);
    check({tag, "_bitclks"}, n_bitclk, exp_clk);
    check({tag, "_ack_hi"}, n_ack_hi, exp_err ? 1 : 0);
    check({tag, "_idle_scl"}, scl, 1'b1);
    check({tag, "_idle_sda"}, sda, 1'b1);
  endtask

  initial begin
    #30_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ena_write = 1'b0; data = '0; cmd_data = 1'b0;
    rst_n = 1'b1;
    #10 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_scl", scl, 1'b1);
    check("rst_sda", sda, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done_write, 1'b0);
    check("rst_ack_err", ack_err, 1'b0);

    // Command 0x28, request on the first edge after reset release.
    clear_mon();
    @(negedge clk);
    rst_n = 1'b1; data = 8'h28; cmd_data = 1'b0; ena_write = 1'b1;
    @(posedge clk);
    #1 ena_write = 1'b0;
    check("first_edge_busy", busy, 1'b1);
    finish_txn("cmd28", 0, 941, 1'b0, 5, 40'h4E_2C_28_8C_88, 45);

    // Character 'A'.
    clear_mon();
    send(8'h41, 1'b1);
    finish_txn("chr41", 0, 941, 1'b0, 5, 40'h4E_4D_49_1D_19, 45);

    // Address NACK: STOP right after the address slot.
    nack_addr = 1'b1;
    clear_mon();
    send(8'hA5, 1'b1);
    finish_txn("nack", 0, 221, 1'b1, 1, 40'h4E, 9);
    nack_addr = 1'b0;

    // Second request 100 cycles in must be ignored.
    clear_mon();
    send(8'h30, 1'b0);
    for (int i = 1; i <= 100; i++) @(negedge clk);
    data = 8'hFF; cmd_data = 1'b1; ena_write = 1'b1;
    @(posedge clk);
    #1 ena_write = 1'b0;
    finish_txn("busyreq", 100, 941, 1'b0, 5, 40'h4E_3C_38_0C_08, 45);
    repeat (60) @(negedge clk);
    check("busyreq_one_done", n_done, 1);
    check("busyreq_still_idle", busy, 1'b0);

    // Reset at cycle 300 abandons the transfer.
    clear_mon();
    send(8'h55, 1'b0);
    for (int i = 1; i < 300; i++) @(negedge clk);
    check("midrst_busy_before", busy, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_scl", scl, 1'b1);
    check("midrst_sda", sda, 1'b1);
    check("midrst_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (1200) @(negedge clk);
    check("midrst_no_done", n_done, 0);
    check("midrst_idle_busy", busy, 1'b0);

    // Fresh request after the reset completes normally.
    clear_mon();
    send(8'h0F, 1'b1);
    finish_txn("postrst", 0, 941, 1'b0, 5, 40'h4E_0D_09_FD_F9, 45);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
